// File: rtl/sata_transport_dma_tx_if.sv
// Stream bundle between the host payload source, the DMA TX transport and the link layer.
// Ports: s_aixs_user_* host payload stream, m_aixs_link_* FIS stream with tuser {drop,err,keep,sop,eop}.
interface sata_transport_dma_tx_if #(
    parameter int USER_W = 8
);
    logic [31:0]       s_aixs_user_tdata;
    logic              s_aixs_user_tvalid;
    logic              s_aixs_user_tready;
    logic [31:0]       m_aixs_link_tdata;
    logic [USER_W-1:0] m_aixs_link_tuser;
    logic              m_aixs_link_tvalid;
    logic              m_aixs_link_tready;

    // Transport block side
    modport master (
        input  s_aixs_user_tdata,
        input  s_aixs_user_tvalid,
        output s_aixs_user_tready,
        output m_aixs_link_tdata,
        output m_aixs_link_tuser,
        output m_aixs_link_tvalid,
        input  m_aixs_link_tready
    );

    // Host source / link layer side
    modport slave (
        output s_aixs_user_tdata,
        output s_aixs_user_tvalid,
        input  s_aixs_user_tready,
        input  m_aixs_link_tdata,
        input  m_aixs_link_tuser,
        input  m_aixs_link_tvalid,
        output m_aixs_link_tready
    );
endinterface

// File: rtl/sata_transport_dma_tx.sv
// SATA transport-layer DMA write TX: splits a command into Data FISes (0x46 header + payload).
// Ports: clk, rst (sync, active-high), cmd_start/cmd_dw_cnt, dma_active, bus (streams), busy, cmd_done, dma_err.
module sata_transport_dma_tx #(
    parameter int USER_W     = 8,
    parameter int MAX_FIS_DW = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_start,
    input  logic [23:0]            cmd_dw_cnt,
    input  logic                   dma_active,
    sata_transport_dma_tx_if.master bus,
    output logic                   busy,
    output logic                   cmd_done,
    output logic                   dma_err
);
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HDR,
        DATA
    } state_t;

    localparam logic [23:0] MAX_DW = 24'(MAX_FIS_DW);

    state_t            state;
    logic [23:0]       remaining;
    logic [11:0]       fis_cnt;
    logic [11:0]       fis_len;
    logic              link_hs;
    logic [7:0]        user8;
    logic [USER_W-1:0] user;

    assign busy    = (state != IDLE);
    assign link_hs = bus.m_aixs_link_tvalid && bus.m_aixs_link_tready;
    assign fis_len = (remaining < MAX_DW) ? remaining[11:0] : MAX_DW[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            fis_cnt   <= '0;
            cmd_done  <= 1'b0;
            dma_err   <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            // Requests that arrive in the wrong state are dropped and flagged
            dma_err  <= (cmd_start && state != IDLE) ||
                        (dma_active && state != ARMED);
            unique case (state)
                IDLE: begin
                    if (cmd_start) begin
                        if (cmd_dw_cnt != '0) begin
                            remaining <= cmd_dw_cnt;
                            state     <= ARMED;
                        end else begin
                            cmd_done <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (dma_active) begin
                        fis_cnt <= fis_len;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (bus.m_aixs_link_tready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (link_hs) begin
                        fis_cnt   <= fis_cnt - 12'd1;
                        remaining <= remaining - 24'd1;
                        if (fis_cnt == 12'd1) begin
                            if (remaining == 24'd1) begin
                                state    <= IDLE;
                                cmd_done <= 1'b1;
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Header is a fixed word; payload is a straight combinational pass-through
    always_comb begin
        bus.m_aixs_link_tdata  = '0;
        bus.m_aixs_link_tvalid = 1'b0;
        bus.s_aixs_user_tready = 1'b0;
        user8                  = '0;
        unique case (state)
            HDR: begin
                bus.m_aixs_link_tdata  = 32'h4600_0000;
                bus.m_aixs_link_tvalid = 1'b1;
                user8                  = {2'b00, 4'hF, 1'b1, 1'b0};
            end
            DATA: begin
                bus.m_aixs_link_tdata  = bus.s_aixs_user_tdata;
                bus.m_aixs_link_tvalid = bus.s_aixs_user_tvalid;
                bus.s_aixs_user_tready = bus.m_aixs_link_tready;
                user8                  = {2'b00, 4'hF, 1'b0, fis_cnt == 12'd1};
            end
            default: ;
        endcase
    end

    always_comb begin
        user      = '0;
        user[7:0] = user8;
    end

    assign bus.m_aixs_link_tuser = user;
endmodule

// File: doc/sata_transport_dma_tx.md
SATA_TRANSPORT_DMA_TX -- requirements
Module: sata_transport_dma_tx

Interface
REQ-001 SHALL have parameter USER_W, default 8: width of the link-side tuser field {drop,err,keep[3:0],sop,eop}.
REQ-002 SHALL have parameter MAX_FIS_DW, default 2048: maximum payload dwords per Data FIS.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have cmd_start  input  1  one-cycle pulse that loads a DMA write command.
REQ-007 SHALL have cmd_dw_cnt  input  24  total payload dwords for the command, sampled with cmd_start.
REQ-008 SHALL have dma_active  input  1  one-cycle pulse from the DMA-activate detector granting one Data FIS.
REQ-009 SHALL have s_aixs_user_tdata  input  32  host payload dword.
REQ-010 SHALL have s_aixs_user_tvalid  input  1  host payload valid.
REQ-011 SHALL have s_aixs_user_tready  output  1  host payload ready.
REQ-012 SHALL have m_aixs_link_tdata  output  32  FIS dword to link layer.
REQ-013 SHALL have m_aixs_link_tuser  output  USER_W  {drop,err,keep[3:0],sop,eop} as bits [7:0].
REQ-014 SHALL have m_aixs_link_tvalid  output  1  link dword valid.
REQ-015 SHALL have m_aixs_link_tready  input  1  link layer ready.
REQ-016 SHALL have busy  output  1  high whenever a command is loaded.
REQ-017 SHALL have cmd_done  output  1  one-cycle pulse when all command dwords are sent.
REQ-018 SHALL have dma_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-019 SHALL implement states IDLE, ARMED, HDR, DATA; busy = (state != IDLE).
REQ-020 IDLE: cmd_start with cmd_dw_cnt>0 SHALL load remaining counter (24 bit) and go ARMED; with cmd_dw_cnt==0 SHALL stay IDLE and pulse cmd_done next cycle.
REQ-021 cmd_start outside IDLE SHALL be ignored and pulse dma_err next cycle.
REQ-022 ARMED: dma_active SHALL load fis_cnt = min(remaining, MAX_FIS_DW) (12 bit) and go HDR next cycle.
REQ-023 dma_active in IDLE, HDR or DATA SHALL be ignored and pulse dma_err next cycle.
REQ-024 HDR: SHALL drive m_tvalid=1, m_tdata=32'h4600_0000 (FIS type 0x46 in bits [31:24]), tuser sop=1, eop=0, keep=4'hF, drop=0, err=0; s_tready=0; on m_tready go DATA.
REQ-025 DATA: SHALL pass through combinationally: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready; tuser sop=0, keep=4'hF, eop=(fis_cnt==1).
REQ-026 Each DATA handshake (m_tvalid && m_tready) SHALL decrement fis_cnt and remaining by 1.
REQ-027 Handshake on the eop dword: remaining becomes 0 -> IDLE with cmd_done pulse next cycle; otherwise -> ARMED.
REQ-028 Outside HDR/DATA, m_tvalid and s_tready SHALL be 0.
REQ-029 Latency: dma_active at cycle N -> header valid at N+1; first payload dword valid earliest N+2.
REQ-030 Header and data SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-031 Simultaneous cmd_done-producing handshake and cmd_start SHALL ignore cmd_start with dma_err.

Reset
REQ-032 rst SHALL force state IDLE, remaining=0, fis_cnt=0, busy=0, cmd_done=0, dma_err=0, m_tvalid=0, s_tready=0, m_tdata=0, m_tuser=0.
REQ-033 rst asserted mid-FIS SHALL abandon the FIS without eop; no cmd_done follows.

Verification
REQ-034 cmd_start cnt=4, dma_active, m_tready=1, source always valid -> 5 dwords: 0x46000000 sop, 4 payload, eop on 4th; cmd_done one cycle after.
REQ-035 cnt=2049 -> first FIS 1 hdr+2048 eop, ARMED; second dma_active -> hdr+1 dword eop; single cmd_done.
REQ-036 cnt=3, random m_tready/s_tvalid backpressure -> data order and values unchanged, no dword lost or duplicated.
REQ-037 dma_active in IDLE and during DATA -> dma_err pulse, FIS stream unaffected; cmd_start cnt=0 -> cmd_done, busy stays 0.
REQ-038 rst during DATA after 2 of 8 dwords -> all outputs 0 next cycle, busy=0, no cmd_done.
